// File: rtl/sequence_serializer.sv
// Parallel-to-serial word shifter feeding sequence_detector, MSB of the selected length first.
// Latency: first bit one cycle after accept; back-to-back words stream without bubbles.
// Backpressure: load_ready only when idle or on a word's last bit; SERIALIZER_GAP_EN inserts GAP_CYCLES idle cycles.
module sequence_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter logic IDLE_BIT   = 1'b0,
    parameter int   GAP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    if (WIDTH < 2 || GAP_CYCLES < 1 || (1 << LEN_W) <= WIDTH) begin : g_param_check
        $error("sequence_serializer: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             seq_q, seq_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] sh_amt;
    logic [WIDTH-1:0] word_aligned;
    logic             accept;

`ifdef SERIALIZER_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // Left-align the selected bits so the shifter always emits from the MSB.
    assign len_eff      = (len_in == '0 || len_in > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_in;
    assign sh_amt       = LEN_W'(WIDTH) - len_eff;
    assign word_aligned = data_in << sh_amt;
    assign accept       = load_valid & load_ready;

    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            ST_IDLE:  load_ready = 1'b1;
`ifdef SERIALIZER_GAP_EN
            ST_SHIFT: load_ready = 1'b0;
            ST_GAP:   load_ready = (gap_q == '0);
`else
            ST_SHIFT: load_ready = (cnt_q == '0);
`endif
            default:  load_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        seq_d       = IDLE_BIT;
        bit_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef SERIALIZER_GAP_EN
        gap_d       = gap_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    seq_d       = shreg_q[WIDTH-1];
                    shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d       = cnt_q - LEN_W'(1);
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    done_d = 1'b1;
`ifdef SERIALIZER_GAP_EN
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    busy_d  = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SERIALIZER_GAP_EN
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d  = gap_q - GAP_W'(1);
                    busy_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A new word overrides whatever the current state would do next.
        if (accept) begin
            state_d     = ST_SHIFT;
            seq_d       = word_aligned[WIDTH-1];
            shreg_d     = {word_aligned[WIDTH-2:0], 1'b0};
            cnt_d       = len_eff - LEN_W'(1);
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            seq_q       <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIALIZER_GAP_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SERIALIZER_GAP_EN
            gap_q       <= gap_d;
`endif
        end
    end

    assign sequence_out = seq_q;
    assign bit_valid    = bit_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sequence_serializer.sv
// Bench for sequence_serializer: directed cases then random words against a bit-queue reference model.
// Latency: outputs compared every cycle, 1 time unit after the rising edge.
// Backpressure: the source holds each word until the model says it is accepted.
module tb_sequence_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_GAP_EN
    localparam int MG = 2;
`else
    localparam int MG = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic [3:0]   len_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         sequence_out;
    logic         bit_valid;
    logic         busy;
    logic         done;

    always #5 clock = ~clock;

    sequence_serializer #(
        .WIDTH(W), .LEN_W(4), .IDLE_BIT(1'b0), .GAP_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .len_in(len_in),
        .load_valid(load_valid), .load_ready(load_ready), .sequence_out(sequence_out),
        .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    typedef struct {
        bit b;
        bit last;
    } sbit_t;

    // Reference: bits still to be emitted, plus what the current cycle shows.
    sbit_t pend[$];
    bit    m_valid, m_bit, m_last, m_done;
    int    m_gap;
    bit    last_acc;
    int    n_checks, n_fail, bv_count;

    function automatic bit m_ready();
        return (pend.size() == 0) && (MG == 0 || (!m_valid && m_gap <= 1));
    endfunction

    function automatic void model_step(input bit acc, input logic [W-1:0] d, input logic [3:0] l);
        int    len;
        int    gap_n;
        bit    done_n;
        sbit_t e;
        if (reset) begin
            pend.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_done  = 1'b0;
            m_gap   = 0;
            return;
        end
        if (acc) begin
            len = (l == 0 || l > W) ? W : int'(l);
            for (int i = len - 1; i >= 0; i--) begin
                e.b    = d[i];
                e.last = (i == 0);
                pend.push_back(e);
            end
        end
        done_n = m_valid && m_last;
        if (m_valid && m_last) gap_n = MG;
        else if (m_gap > 0)    gap_n = m_gap - 1;
        else                   gap_n = 0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (gap_n == 0 && pend.size() > 0) begin
            e       = pend.pop_front();
            m_valid = 1'b1;
            m_bit   = e.b;
            m_last  = e.last;
        end
        m_done = done_n;
        m_gap  = gap_n;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        bit rdy;
        bit acc;
        rdy = m_ready();
        @(posedge clock);
        acc = !reset && load_valid && rdy;
        model_step(acc, data_in, len_in);
        last_acc = acc;
        #1;
        check_bit("bit_valid", bit_valid, m_valid);
        check_bit("sequence_out", sequence_out, m_valid ? m_bit : 1'b0);
        check_bit("busy", busy, m_valid || (m_gap > 0));
        check_bit("done", done, m_done);
        check_bit("load_ready", load_ready, m_ready());
        if (bit_valid === 1'b1) bv_count++;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [3:0] l);
        int n;
        load_valid = 1'b1;
        data_in    = d;
        len_in     = l;
        n          = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 64);
        if (!last_acc) begin
            n_checks++;
            n_fail++;
            $error("FAIL accept_timeout observed=no accept expected=accept within 64 cycles");
        end
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        data_in    = W'($urandom);
        len_in     = 4'($urandom);
        repeat (n) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bv_count = 0;
        m_valid  = 1'b0;
        m_bit    = 1'b0;
        m_last   = 1'b0;
        m_done   = 1'b0;
        m_gap    = 0;
        last_acc = 1'b0;

        // Reset held with a word offered: nothing may be accepted.
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        len_in     = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        idle(2);

        bv_count = 0;
        send_word(8'h0B, 4'd4);
        idle(6);
        check_int("single_word_bits", bv_count, 4);

        bv_count = 0;
        send_word(8'h05, 4'd3);
        send_word(8'h03, 4'd3);
        idle(6 + 2 * MG);
        check_int("two_word_bits", bv_count, 6);

        // Reset while the third bit of an 8-bit word is on the line.
        send_word(8'hC3, 4'd8);
        load_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bv_count = 0;
        idle(10);
        check_int("post_abort_bits", bv_count, 0);

        bv_count = 0;
        send_word(8'hA5, 4'd0);
        idle(10);
        check_int("len0_bits", bv_count, 8);
        bv_count = 0;
        send_word(8'hA5, 4'd12);
        idle(10);
        check_int("len12_bits", bv_count, 8);

        bv_count = 0;
        send_word(8'h01, 4'd1);
        send_word(8'h00, 4'd1);
        send_word(8'hFF, 4'd1);
        idle(4 + 3 * MG);
        check_int("len1_stream_bits", bv_count, 3);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            idle($urandom_range(0, 2));
            send_word(W'($urandom), 4'($urandom_range(0, 15)));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
